vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 139 +++++++++++++
 tb/tb_vram_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Video memory arbiter: display scan fetches take priority over host access.
// A granted host access always finishes first; a scan arriving meanwhile is held pending.
module vram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_valid,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_overrun,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN_RD,
        SCAN_WAIT,
        CPU_RD,
        CPU_WAIT,
        CPU_WR
    } state_t;

    state_t state;

    logic              pend;
    logic [ADDR_W-1:0] pend_addr;

    logic              scan_go;
    logic              cpu_wr_go;
    logic              cpu_rd_go;
    logic [ADDR_W-1:0] scan_tgt;

    // A fresh strobe supersedes whatever address is already pending.
    always_comb begin
        scan_go   = pend || scan_req;
        scan_tgt  = scan_req ? scan_addr : pend_addr;
        cpu_wr_go = !scan_go && cpu_req && cpu_we;
        cpu_rd_go = !scan_go && cpu_req && !cpu_we;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= IDLE;
            pend         <= 1'b0;
            pend_addr    <= '0;
            scan_valid   <= 1'b0;
            scan_data    <= '0;
            scan_overrun <= 1'b0;
            cpu_ack      <= 1'b0;
            cpu_rdata    <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            scan_valid <= 1'b0;
            cpu_ack    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;

            if (scan_req) begin
                pend      <= 1'b1;
                pend_addr <= scan_addr;
                if (pend) begin
                    scan_overrun <= 1'b1;
                end
            end

            if (state == SCAN_WAIT) begin
                scan_valid <= 1'b1;
                scan_data  <= mem_rdata;
            end

            unique case (state)
                IDLE, SCAN_WAIT: begin
                    unique case (1'b1)
                        scan_go: begin
                            state    <= SCAN_RD;
                            pend     <= 1'b0;
                            mem_en   <= 1'b1;
                            mem_addr <= scan_tgt;
                        end
                        cpu_wr_go: begin
                            state     <= CPU_WR;
                            mem_en    <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end
                        cpu_rd_go: begin
                            state    <= CPU_RD;
                            mem_en   <= 1'b1;
                            mem_addr <= cpu_addr;
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
                SCAN_RD: begin
                    state <= SCAN_WAIT;
                end
                CPU_RD: begin
                    state <= CPU_WAIT;
                end
                CPU_WAIT: begin
                    state     <= IDLE;
                    cpu_ack   <= 1'b1;
                    cpu_rdata <= mem_rdata;
                end
                CPU_WR: begin
                    state   <= IDLE;
                    cpu_ack <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_we_needs_en: assert property (
        @(posedge clk) disable iff (!nrst) mem_we |-> mem_en
    );

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized scan/host traffic
// checked every cycle against an occupancy-based reference model.
module tb_vram_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          scan_req = 1'b0;
    logic [AW-1:0] scan_addr = '0;
    logic          scan_valid;
    logic [DW-1:0] scan_data;
    logic          scan_overrun;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk),
        .nrst(nrst),
        .scan_req(scan_req),
        .scan_addr(scan_addr),
        .scan_valid(scan_valid),
        .scan_data(scan_data),
        .scan_overrun(scan_overrun),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 'h0123) return 16'hBEEF;
        if (a == 'h0020) return 16'h1234;
        return DW'(a) ^ 16'hA5A5;
    endfunction

    // Synchronous video RAM: read data appears the cycle after the access.
    logic [DW-1:0] ram [0:DEPTH-1];
    bit ram_ok = 1'b0;

    always @(posedge clk) begin
        if (!ram_ok) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
            ram_ok = 1'b1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end
    end

    // Reference model: the arbiter is busy for a fixed number of cycles per
    // access (scan 2, write 2, read 3) and otherwise grants scans first.
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    bit            mdl_ok = 1'b0;
    int            m_cyc, m_next, sv_due, ack_due;
    bit            m_pend, m_ovr, ack_rd;
    logic [AW-1:0] m_paddr;
    bit            e_en, e_we, e_sv, e_ack;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_sdata, e_rdata, sv_val, ack_val;

    always @(posedge clk or negedge nrst) begin : mdl
        int n;
        logic [AW-1:0] a;
        if (!mdl_ok) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
            mdl_ok = 1'b1;
        end
        if (!nrst) begin
            m_cyc = 0; m_next = 0; sv_due = -1; ack_due = -1;
            m_pend = 0; m_ovr = 0; ack_rd = 0; m_paddr = '0;
            e_en = 0; e_we = 0; e_sv = 0; e_ack = 0;
            e_addr = '0; e_wdata = '0; e_sdata = '0; e_rdata = '0;
            sv_val = '0; ack_val = '0;
        end else begin
            n = m_cyc + 1;
            e_en = 0;
            e_we = 0;
            e_sv = (sv_due == n);
            if (e_sv) e_sdata = sv_val;
            e_ack = (ack_due == n);
            if (e_ack && ack_rd) e_rdata = ack_val;
            if (n >= m_next && (m_pend || scan_req)) begin
                a = scan_req ? scan_addr : m_paddr;
                if (scan_req && m_pend) m_ovr = 1;
                m_pend = 0;
                e_en = 1;
                e_addr = a;
                sv_val = ref_mem[a];
                sv_due = n + 2;
                m_next = n + 2;
            end else begin
                if (scan_req) begin
                    if (m_pend) m_ovr = 1;
                    m_pend = 1;
                    m_paddr = scan_addr;
                end
                if (n >= m_next && cpu_req) begin
                    e_en = 1;
                    e_addr = cpu_addr;
                    if (cpu_we) begin
                        e_we = 1;
                        e_wdata = cpu_wdata;
                        ref_mem[cpu_addr] = cpu_wdata;
                        ack_rd = 0;
                        ack_due = n + 1;
                        m_next = n + 2;
                    end else begin
                        ack_rd = 1;
                        ack_val = ref_mem[cpu_addr];
                        ack_due = n + 2;
                        m_next = n + 3;
                    end
                end
            end
            m_cyc = n;
        end
    end

    int we_cnt = 0;
    int sv_cnt = 0;

    always @(negedge clk) begin
        if (nrst && mdl_ok) begin
            chk("scan_valid", 32'(scan_valid), 32'(e_sv));
            chk("scan_data", 32'(scan_data), 32'(e_sdata));
            chk("scan_overrun", 32'(scan_overrun), 32'(m_ovr));
            chk("cpu_ack", 32'(cpu_ack), 32'(e_ack));
            chk("cpu_rdata", 32'(cpu_rdata), 32'(e_rdata));
            chk("mem_en", 32'(mem_en), 32'(e_en));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            if (e_en) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            if (e_en && e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
            if (mem_en && mem_we) we_cnt++;
            if (scan_valid) sv_cnt++;
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  wc0, sc0;
        time t_end;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_flags", 32'({scan_valid, scan_overrun, cpu_ack, mem_en, mem_we}), 0);
        chk("rst_data", 32'({scan_data, cpu_rdata}), 0);
        #4 nrst = 1'b1;
        tick;

        // Idle scan: fetch at cycle 1, data at cycle 3.
        scan_req = 1; scan_addr = 16'h0123;
        tick;
        scan_req = 0;
        chk("t20_en", 32'(mem_en), 1);
        chk("t20_addr", 32'(mem_addr), 32'h0123);
        tick;
        chk("t20_early", 32'(scan_valid), 0);
        tick;
        chk("t20_sv", 32'(scan_valid), 1);
        chk("t20_sd", 32'(scan_data), 32'hBEEF);
        tick;
        chk("t20_strobe", 32'(scan_valid), 0);

        // Simultaneous scan and host read.
        repeat (3) tick;
        scan_req = 1; scan_addr = 16'h0010;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
        tick;
        scan_req = 0;
        tick;
        tick;
        chk("t21_sv", 32'(scan_valid), 1);
        chk("t21_sd", 32'(scan_data), 32'hA5B5);
        chk("t21_cpu_en", 32'({mem_en, mem_we}), 32'b10);
        chk("t21_cpu_addr", 32'(mem_addr), 32'h0020);
        tick;
        chk("t21_ack_early", 32'(cpu_ack), 0);
        tick;
        chk("t21_ack", 32'(cpu_ack), 1);
        chk("t21_rdata", 32'(cpu_rdata), 32'h1234);
        cpu_req = 0;

        // Host write followed by read-back.
        tick;
        wc0 = we_cnt;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0100; cpu_wdata = 16'h5A5A;
        tick;
        chk("t22_we", 32'(mem_we), 1);
        chk("t22_wdata", 32'(mem_wdata), 32'h5A5A);
        tick;
        chk("t22_wack", 32'(cpu_ack), 1);
        cpu_req = 0;
        tick;
        cpu_req = 1; cpu_we = 0;
        tick;
        chk("t22_rd_en", 32'({mem_en, mem_we}), 32'b10);
        tick;
        chk("t22_rack_early", 32'(cpu_ack), 0);
        tick;
        chk("t22_rack", 32'(cpu_ack), 1);
        chk("t22_rdata", 32'(cpu_rdata), 32'h5A5A);
        cpu_req = 0;
        repeat (2) tick;
        chk("t22_we_cycles", 32'(we_cnt - wc0), 1);

        // Scan arriving while a host read is in flight.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
        tick;
        chk("t23_cpu_rd", 32'(mem_en), 1);
        scan_req = 1; scan_addr = 16'h0200;
        tick;
        scan_req = 0;
        tick;
        chk("t23_ack", 32'(cpu_ack), 1);
        cpu_req = 0;
        tick;
        chk("t23_scan_addr", 32'(mem_addr), 32'h0200);
        tick;
        chk("t23_early", 32'(scan_valid), 0);
        tick;
        chk("t23_sv", 32'(scan_valid), 1);
        chk("t23_sd", 32'(scan_data), 32'hA7A5);
        chk("t23_no_ovr", 32'(scan_overrun), 0);

        // Back-to-back scan strobes during a host read.
        repeat (2) tick;
        sc0 = sv_cnt;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0041;
        tick;
        scan_req = 1; scan_addr = 16'h0300;
        tick;
        scan_addr = 16'h0301;
        tick;
        scan_req = 0;
        cpu_req = 0;
        chk("t24_ovr", 32'(scan_overrun), 1);
        tick;
        chk("t24_addr", 32'(mem_addr), 32'h0301);
        repeat (2) tick;
        chk("t24_sv", 32'(scan_valid), 1);
        chk("t24_sd", 32'(scan_data), 32'hA6A4);
        repeat (6) tick;
        chk("t24_sv_count", 32'(sv_cnt - sc0), 1);
        chk("t24_ovr_sticky", 32'(scan_overrun), 1);

        // Reset asserted while a host read waits for data.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
        tick;
        tick;
        #2 nrst = 1'b0;
        #1;
        chk("t25_flags", 32'({scan_valid, scan_overrun, cpu_ack, mem_en, mem_we}), 0);
        chk("t25_data", 32'({scan_data, cpu_rdata}), 0);
        chk("t25_mem", 32'({mem_addr, mem_wdata}), 0);
        cpu_req = 0;
        repeat (3) begin
            tick;
            chk("t25_no_ack", 32'(cpu_ack), 0);
        end
        @(posedge clk);
        #7 nrst = 1'b1;
        tick;
        chk("t25_idle", 32'({cpu_ack, mem_en}), 0);
        scan_req = 1; scan_addr = 16'h0123;
        tick;
        scan_req = 0;
        chk("t25_resume_en", 32'(mem_en), 1);
        repeat (2) tick;
        chk("t25_resume_sv", 32'(scan_valid), 1);
        chk("t25_resume_sd", 32'(scan_data), 32'hBEEF);
        repeat (2) tick;

        // Randomized traffic, scan strobes spaced at least 6 cycles apart.
        t_end = $time + 30000;
        fork
            begin
                while ($time < t_end) begin
                    scan_req = 1;
                    scan_addr = AW'($urandom_range(0, 31));
                    tick;
                    scan_req = 0;
                    repeat ($urandom_range(5, 12)) tick;
                end
            end
            begin
                bit got;
                while ($time < t_end) begin
                    repeat ($urandom_range(0, 4)) tick;
                    cpu_we = 1'($urandom_range(0, 1));
                    cpu_addr = AW'($urandom_range(0, 31));
                    cpu_wdata = DW'($urandom);
                    cpu_req = 1;
                    got = 0;
                    for (int k = 0; k < 30 && !got; k++) begin
                        tick;
                        if (cpu_ack) got = 1;
                    end
                    cpu_req = 0;
                    if (!got) chk("cpu_ack_timeout", 0, 1);
                end
            end
        join
        repeat (10) tick;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
